// File: rtl/ram_ctrl.sv
// Request/response front end for a 32-bit synchronous RAM: clears the array after reset,
// then turns valid/ready requests into RAM cycles and buffers read data until it is taken.
module ram_ctrl #(
  parameter int          BUS_WIDTH  = 14,
  parameter bit          INIT_CLEAR = 1'b1,
  parameter logic [31:0] INIT_VALUE = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 init_done,
  output logic [BUS_WIDTH-1:0] ram_addr,
  output logic [31:0]          ram_dataIn,
  output logic                 ram_wrEnable,
  input  logic [31:0]          ram_dataOut,
  output logic [1:0]           fsm_state
);

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  localparam logic [BUS_WIDTH-1:0] INIT_LAST = '1;

  // Handshake rule for both channels: a transfer happens on a rising edge where valid and
  // ready are both high; valid and its payload must then stay stable until that edge.

  logic [1:0]           state;
  logic [BUS_WIDTH-1:0] init_cnt;
  logic [BUS_WIDTH-1:0] addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT_CLEAR ? S_INIT : S_IDLE;
      init_cnt  <= '0;
      addr_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      init_done <= !INIT_CLEAR;
    end else begin
      case (state)
        S_INIT: begin
          // Hold the counter on the last word so it never wraps back to zero.
          if (init_cnt == INIT_LAST) begin
            state     <= S_IDLE;
            init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid && !req_write) begin
            addr_q <= req_addr;
            state  <= S_RD;
          end
        end
        S_RD: begin
          rsp_rdata <= ram_dataOut;
          rsp_valid <= 1'b1;
          state     <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_addr     = addr_q;
    ram_dataIn   = '0;
    ram_wrEnable = 1'b0;
    case (state)
      S_INIT: begin
        ram_addr     = init_cnt;
        ram_dataIn   = INIT_VALUE;
        ram_wrEnable = 1'b1;
      end
      S_IDLE: begin
        ram_addr     = req_addr;
        ram_dataIn   = req_wdata;
        ram_wrEnable = req_valid & req_write;
      end
      default: ;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: RAM stubs, a transaction-level reference model with an expected-read
// queue, a per-cycle compare process, directed scenarios and a randomized traffic phase.
`timescale 1ns/1ps
module tb_ram_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n    = 1'b1;
  logic nc_rst_n = 1'b1;

  // ---------------- main DUT (INIT_CLEAR=1) ----------------
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [3:0]  req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, init_done, ram_wrEnable;
  logic [31:0] rsp_rdata, ram_dataIn;
  logic [31:0] ram_dataOut;
  logic [3:0]  ram_addr;
  logic [1:0]  fsm_state;

  ram_ctrl #(.BUS_WIDTH(4), .INIT_CLEAR(1'b1), .INIT_VALUE(32'h0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_wrEnable(ram_wrEnable),
    .ram_dataOut(ram_dataOut), .fsm_state(fsm_state)
  );

  logic [31:0] ram_mem [16];
  always @(posedge clk) begin
    if (ram_wrEnable) ram_mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= ram_mem[ram_addr];
  end

  // ---------------- second DUT (INIT_CLEAR=0) ----------------
  logic        nc_req_valid = 1'b0;
  logic [3:0]  nc_req_addr  = '0;
  logic        nc_req_ready, nc_rsp_valid, nc_init_done, nc_ram_wrEnable;
  logic [31:0] nc_rsp_rdata, nc_ram_dataIn;
  logic [31:0] nc_ram_dataOut;
  logic [3:0]  nc_ram_addr;
  logic [1:0]  nc_fsm_state;

  ram_ctrl #(.BUS_WIDTH(4), .INIT_CLEAR(1'b0), .INIT_VALUE(32'hA5A5A5A5)) u_nc (
    .clk(clk), .rst_n(nc_rst_n),
    .req_valid(nc_req_valid), .req_ready(nc_req_ready), .req_write(1'b0),
    .req_addr(nc_req_addr), .req_wdata(32'h0),
    .rsp_valid(nc_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(nc_rsp_rdata),
    .init_done(nc_init_done),
    .ram_addr(nc_ram_addr), .ram_dataIn(nc_ram_dataIn), .ram_wrEnable(nc_ram_wrEnable),
    .ram_dataOut(nc_ram_dataOut), .fsm_state(nc_fsm_state)
  );

  logic [31:0] nc_mem [16] = '{32'h5000, 32'h5001, 32'h5002, 32'h5003,
                               32'h5004, 32'h5005, 32'h5006, 32'h5007,
                               32'h5008, 32'h5009, 32'h500A, 32'h500B,
                               32'h500C, 32'h500D, 32'h500E, 32'h500F};
  always @(posedge clk) begin
    if (nc_ram_wrEnable) nc_mem[nc_ram_addr] <= nc_ram_dataIn;
    nc_ram_dataOut <= nc_mem[nc_ram_addr];
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_init_left = 16;
  bit          m_done      = 1'b0;
  bit          m_rd_pend   = 1'b0;
  bit          m_rsp_valid = 1'b0;
  logic [31:0] m_rsp_data  = '0;
  logic [31:0] ref_mem [16];
  logic [31:0] exp_q [$];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_init_left = 16;
      m_done      = 1'b0;
      m_rd_pend   = 1'b0;
      m_rsp_valid = 1'b0;
      m_rsp_data  = '0;
      exp_q.delete();
    end else if (m_init_left > 0) begin
      m_init_left--;
      if (m_init_left == 0) begin
        m_done = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
      end
    end else if (m_rd_pend) begin
      m_rsp_data  = exp_q.pop_front();
      m_rsp_valid = 1'b1;
      m_rd_pend   = 1'b0;
    end else if (m_rsp_valid) begin
      if (rsp_ready) m_rsp_valid = 1'b0;
    end else if (req_valid) begin
      if (req_write) ref_mem[req_addr] = req_wdata;
      else begin
        exp_q.push_back(ref_mem[req_addr]);
        m_rd_pend = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;

  initial forever begin
    logic exp_ready, exp_we;
    @(negedge clk);
    if (cmp_en) begin
      exp_ready = (m_init_left == 0) && !m_rd_pend && !m_rsp_valid;
      exp_we    = (m_init_left > 0) ? 1'b1 : (exp_ready & req_valid & req_write);
      check("req_ready",    {31'b0, req_ready},    {31'b0, exp_ready});
      check("init_done",    {31'b0, init_done},    {31'b0, m_done});
      check("rsp_valid",    {31'b0, rsp_valid},    {31'b0, m_rsp_valid});
      check("rsp_rdata",    rsp_rdata,             m_rsp_data);
      check("ram_wrEnable", {31'b0, ram_wrEnable}, {31'b0, exp_we});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_init(output int cycles);
    cycles = 0;
    while (!init_done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    int guard = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    while (!req_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d, output int lat);
    int guard = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; rsp_ready = 1'b1;
    while (!req_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d = rsp_rdata;
    @(posedge clk); #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          cyc, lat, stalls, guard;
    logic [31:0] rd, held;

    #1 rst_n = 1'b0; nc_rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", {31'b0, req_ready}, 32'd0);
    check("reset_init_done", {31'b0, init_done}, 32'd0);

    // 1: clear takes exactly 16 cycles, then read a cleared word
    rst_n = 1'b1;
    wait_init(cyc);
    check("init_cycles", cyc, 32'd16);
    do_read(4'd7, rd, lat);
    check("read7_after_clear", rd, 32'h0);

    // 2: write then read of the same address on the next cycle
    do_write(4'd3, 32'hDEADBEEF);
    do_read(4'd3, rd, lat);
    check("wr_rd_data", rd, 32'hDEADBEEF);
    check("rd_latency", lat, 32'd2);

    // 3: back-to-back writes with no stall, then read-back
    stalls = 0;
    req_valid = 1'b1; req_write = 1'b1;
    for (int a = 0; a < 16; a++) begin
      req_addr = 4'(a); req_wdata = 32'h100 + a;
      if (!req_ready) stalls++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("b2b_stalls", stalls, 32'd0);
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a), rd, lat);
      check($sformatf("readback_%0d", a), rd, 32'h100 + a);
    end

    // 4: response held under back-pressure
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    held = rsp_rdata;
    check("bp_data", held, 32'h105);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid_hold", {31'b0, rsp_valid}, 32'd1);
      check("bp_data_hold", rsp_rdata, held);
      check("bp_ready_low", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", {31'b0, req_ready}, 32'd1);
    check("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
    check("bp_rdata_kept", rsp_rdata, 32'h105);

    // 5a: reset in the middle of the clear
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_init_addr", {28'b0, ram_addr}, 32'd0);
    check("rst_init_we", {31'b0, ram_wrEnable}, 32'd1);
    check("rst_init_ready", {31'b0, req_ready}, 32'd0);
    check("rst_init_done", {31'b0, init_done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init(cyc);
    check("reinit_cycles", cyc, 32'd16);

    // 5b: reset while a read is in flight
    do_write(4'd9, 32'hCAFE0009);
    do_read(4'd9, rd, lat);
    check("pre_rst_read", rd, 32'hCAFE0009);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_rd_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rd_rdata", rsp_rdata, 32'h0);
    check("rst_rd_done", {31'b0, init_done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init(cyc);
    check("reinit2_cycles", cyc, 32'd16);

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 800; i++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 4'($urandom_range(0, 15));
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 6: no-clear configuration is usable straight out of reset
    check("nc_done_in_reset", {31'b0, nc_init_done}, 32'd1);
    check("nc_ready_in_reset", {31'b0, nc_req_ready}, 32'd1);
    nc_rst_n = 1'b1;
    @(posedge clk); #1;
    check("nc_ready", {31'b0, nc_req_ready}, 32'd1);
    nc_req_valid = 1'b1; nc_req_addr = 4'd15;
    @(posedge clk); #1;
    nc_req_valid = 1'b0;
    guard = 0;
    while (!nc_rsp_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("nc_read15", nc_rsp_rdata, 32'h500F);
    check("nc_mem0_untouched", nc_mem[0], 32'h5000);

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
